// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage; owns the PC, runs the imem read handshake, feeds IF/ID.
// Latency : zero-wait memory gives one instruction per cycle; a redirect target is requested
//           the cycle after BRANCH_TAKEN (or the cycle after an outstanding read drains).
// Backpr. : i_stall parks a returned word in a hold register and stops requesting until released.
//
// Ports
//   i_clk              clock, rising edge
//   i_rst_n            asynchronous reset, active-low
//   i_stall            hazard unit: hold the current instruction, do not advance
//   i_branch_taken     one-cycle redirect request from EX
//   i_branch_target    redirect address, bits [1:0] forced to zero
//   o_imem_read        instruction memory read request
//   o_imem_address     read address, held stable while the memory is busy
//   i_imem_readdata    instruction word, valid when read=1 and busywait=0
//   i_imem_busywait    memory busy
//   o_pc_out           PC of the delivered instruction
//   o_pc_plus_four_out o_pc_out + 4, wrapping modulo 2^32
//   o_instruction_out  fetched instruction, or NOP_INSTR when nothing valid
//   o_instr_valid_out  1 when o_instruction_out is a real fetched instruction

module if_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_read,
  output logic [31:0] o_imem_address,
  input  logic [31:0] i_imem_readdata,
  input  logic        i_imem_busywait,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_pc_plus_four_out,
  output logic [31:0] o_instruction_out,
  output logic        o_instr_valid_out
);

  // The PC is always word aligned, including straight out of reset.
  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  // IDLE  : one cycle after reset release, no request issued.
  // FETCH : request outstanding at r_pc.
  // HOLD  : a word was returned under stall and is parked in r_hold_instr.
  // DRAIN : a redirect arrived while a read was in flight; the old address is
  //         held until the memory completes, then the redirect is applied.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold_instr;
  logic [31:0] w_hold_instr_nxt;
  logic [31:0] r_redirect_pc;
  logic [31:0] w_redirect_pc_nxt;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = {i_branch_target[31:2], 2'b00};
  assign w_pc_plus4 = r_pc + 32'd4;

  // The address and PC outputs come straight from the PC register in every
  // state, so the memory sees a stable address for as long as it stays busy.
  assign o_imem_address     = r_pc;
  assign o_pc_out           = r_pc;
  assign o_pc_plus_four_out = w_pc_plus4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_hold_instr  <= NOP_INSTR;
      r_redirect_pc <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_hold_instr  <= w_hold_instr_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

  // Next-state and output decode. Within a cycle a redirect outranks a stall,
  // which outranks the memory return.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_hold_instr_nxt  = r_hold_instr;
    w_redirect_pc_nxt = r_redirect_pc;
    o_imem_read       = 1'b0;
    o_instruction_out = NOP_INSTR;
    o_instr_valid_out = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        o_imem_read = 1'b1;
        if (i_branch_taken) begin
          if (i_imem_busywait) begin
            // Cannot abandon the in-flight read; remember where to go.
            w_redirect_pc_nxt = w_target;
            w_state_nxt       = S_DRAIN;
          end else begin
            // The returning word is on the wrong path; drop it.
            w_pc_nxt = w_target;
          end
        end else if (!i_imem_busywait) begin
          o_instruction_out = i_imem_readdata;
          o_instr_valid_out = 1'b1;
          if (i_stall) begin
            // Word is presented now and kept until the stall clears.
            w_hold_instr_nxt = i_imem_readdata;
            w_state_nxt      = S_HOLD;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end

      S_HOLD: begin
        if (i_branch_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else begin
          o_instruction_out = r_hold_instr;
          o_instr_valid_out = 1'b1;
          if (!i_stall) begin
            // Held word is consumed by IF/ID on this edge.
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        o_imem_read = 1'b1;
        if (i_branch_taken) begin
          w_redirect_pc_nxt = w_target;
        end
        if (!i_imem_busywait) begin
          // Latest redirect wins, even one arriving on the completing cycle.
          w_pc_nxt    = i_branch_taken ? w_target : r_redirect_pc;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Design invariants: aligned PC, and a busy memory never sees its address move.
  a_pc_aligned : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_pc[1:0] == 2'b00);

  a_addr_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_imem_read && i_imem_busywait) |=> (o_imem_address == $past(o_imem_address)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose : self-checking bench for if_fetch_unit against a flag-based behavioural model.
// Latency : outputs checked 1 time unit after each falling edge, before the next rising edge.
// Backpr. : stall, redirect and memory busy are driven from directed tables and at random.

module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        busy;
  logic [31:0] salt;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic        instr_vld;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address it is asked for.
  assign imem_rdata = imem_addr ^ salt;

  if_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .NOP_INSTR   (NOP)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_stall           (stall),
    .i_branch_taken    (br),
    .i_branch_target   (tgt),
    .o_imem_read       (imem_read),
    .o_imem_address    (imem_addr),
    .i_imem_readdata   (imem_rdata),
    .i_imem_busywait   (busy),
    .o_pc_out          (pc_out),
    .o_pc_plus_four_out(pc4_out),
    .o_instruction_out (instr_out),
    .o_instr_valid_out (instr_vld)
  );

  wire [129:0] dut_vec = {imem_read, imem_addr, pc_out, pc4_out, instr_out, instr_vld};
  logic [129:0] exp_vec;

  // Reference model: a program counter plus "started", "word parked" and
  // "redirect pending" flags, advanced once per clock from the rules of the stage.
  bit          m_started, m_held, m_drain;
  logic [31:0] m_pc, m_word, m_redir;
  bit          n_started, n_held, n_drain;
  logic [31:0] n_pc, n_word, n_redir;

  task automatic model_reset();
    m_started = 0; m_held = 0; m_drain = 0;
    m_pc = 32'h0; m_word = NOP; m_redir = 32'h0;
    n_started = 0; n_held = 0; n_drain = 0;
    n_pc = 32'h0; n_word = NOP; n_redir = 32'h0;
  endtask

  task automatic model_eval();
    bit          e_rd, e_vld;
    logic [31:0] e_ins;
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    n_started = m_started; n_held = m_held; n_drain = m_drain;
    n_pc = m_pc; n_word = m_word; n_redir = m_redir;
    e_rd = 0; e_vld = 0; e_ins = NOP;
    if (!m_started) begin
      n_started = 1;
    end else if (m_held) begin
      if (br) begin
        n_pc = t; n_held = 0;
      end else begin
        e_ins = m_word; e_vld = 1;
        if (!stall) begin n_pc = m_pc + 32'd4; n_held = 0; end
      end
    end else if (m_drain) begin
      e_rd = 1;
      if (br) n_redir = t;
      if (!busy) begin n_pc = n_redir; n_drain = 0; end
    end else begin
      e_rd = 1;
      if (br) begin
        if (busy) begin n_drain = 1; n_redir = t; end
        else n_pc = t;
      end else if (!busy) begin
        e_ins = m_pc ^ salt; e_vld = 1;
        if (stall) begin n_held = 1; n_word = m_pc ^ salt; end
        else n_pc = m_pc + 32'd4;
      end
    end
    exp_vec = {e_rd, m_pc, m_pc, m_pc + 32'd4, e_ins, e_vld};
  endtask

  // One clock: apply the previous cycle's model update, drive, settle, predict.
  task automatic step(input bit s, input bit b, input logic [31:0] t, input bit bz);
    m_started = n_started; m_held = n_held; m_drain = n_drain;
    m_pc = n_pc; m_word = n_word; m_redir = n_redir;
    @(negedge clk);
    stall = s; br = b; tgt = t; busy = bz;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    rst_n = 0; stall = 0; br = 0; tgt = 0; busy = 0;
    repeat (2) @(posedge clk);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1;
  endtask

  typedef struct packed {
    bit          stall;
    bit          br;
    logic [31:0] tgt;
    bit          busy;
    bit          rd;
    logic [31:0] addr;
    bit          vld;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit b, input logic [31:0] t, input bit bz,
                              input bit r, input logic [31:0] a, input bit v);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.busy = bz; x.rd = r; x.addr = a; x.vld = v;
    return x;
  endfunction

  task automatic test_reset();
    vec_t tv[$];
    salt = 32'h0;
    rst_n = 0; stall = 0; br = 0; tgt = 0; busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({imem_read, pc_out, pc4_out, instr_out, instr_vld} !== {1'b0, 32'h0, 32'h4, NOP, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got %h want %h", {imem_read, pc_out, pc4_out, instr_out, instr_vld},
               {1'b0, 32'h0, 32'h4, NOP, 1'b0});
    end
    @(posedge clk);
    #2 rst_n = 1;
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h4, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h8, 1));
    foreach (tv[i]) begin
      step(tv[i].stall, tv[i].br, tv[i].tgt, tv[i].busy);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL reset_seq[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
      n_vec++;
      if ({imem_read, imem_addr, pc_out, instr_vld} !== {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld}) begin
        n_err++; $display("FAIL reset_dir[%0d] got %h want %h", i,
                          {imem_read, imem_addr, pc_out, instr_vld}, {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld});
      end
    end
  endtask

  task automatic test_busywait();
    vec_t tv[$];
    salt = $urandom;
    do_reset();
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h4, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h8, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h8, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h8, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h8, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'hC, 1));
    foreach (tv[i]) begin
      step(tv[i].stall, tv[i].br, tv[i].tgt, tv[i].busy);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL busy_seq[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
      n_vec++;
      if ({imem_read, imem_addr, pc_out, instr_vld} !== {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld}) begin
        n_err++; $display("FAIL busy_dir[%0d] got %h want %h", i,
                          {imem_read, imem_addr, pc_out, instr_vld}, {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld});
      end
    end
  endtask

  // Continues from PC=0x10 left by the busywait test.
  task automatic test_stall_hold();
    vec_t tv[$];
    tv.push_back(mk(1, 0, 0, 0, 1, 32'h10, 1));
    tv.push_back(mk(1, 0, 0, 0, 0, 32'h10, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 32'h10, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h14, 1));
    foreach (tv[i]) begin
      step(tv[i].stall, tv[i].br, tv[i].tgt, tv[i].busy);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL stall_seq[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
      n_vec++;
      if ({imem_read, imem_addr, pc_out, instr_vld} !== {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld}) begin
        n_err++; $display("FAIL stall_dir[%0d] got %h want %h", i,
                          {imem_read, imem_addr, pc_out, instr_vld}, {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld});
      end
    end
  endtask

  task automatic test_branch_drain();
    vec_t tv[$];
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h18, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h1C, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h20, 0));
    tv.push_back(mk(0, 1, 32'h100, 1, 1, 32'h20, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h20, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h100, 1));
    foreach (tv[i]) begin
      step(tv[i].stall, tv[i].br, tv[i].tgt, tv[i].busy);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL drain_seq[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
      n_vec++;
      if ({imem_read, imem_addr, pc_out, instr_vld} !== {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld}) begin
        n_err++; $display("FAIL drain_dir[%0d] got %h want %h", i,
                          {imem_read, imem_addr, pc_out, instr_vld}, {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld});
      end
    end
  endtask

  task automatic test_branch_in_hold();
    vec_t tv[$];
    tv.push_back(mk(1, 0, 0, 0, 1, 32'h104, 1));
    tv.push_back(mk(1, 1, 32'h203, 0, 0, 32'h104, 0));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h200, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h204, 1));
    foreach (tv[i]) begin
      step(tv[i].stall, tv[i].br, tv[i].tgt, tv[i].busy);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL hold_br_seq[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
      n_vec++;
      if ({imem_read, imem_addr, pc_out, instr_vld} !== {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld}) begin
        n_err++; $display("FAIL hold_br_dir[%0d] got %h want %h", i,
                          {imem_read, imem_addr, pc_out, instr_vld}, {tv[i].rd, tv[i].addr, tv[i].addr, tv[i].vld});
      end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    step(0, 1, 32'hFFFF_FFFC, 0);
    n_vec++;
    if (dut_vec !== exp_vec) begin
      n_err++; $display("FAIL wrap_redirect got %h want %h", dut_vec, exp_vec);
    end
    step(0, 0, 0, 0);
    n_vec++;
    if ({pc_out, pc4_out, instr_vld} !== {32'hFFFF_FFFC, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL wrap_pc4 got %h want %h", {pc_out, pc4_out, instr_vld}, {32'hFFFF_FFFC, 32'h0, 1'b1});
    end
    step(0, 0, 0, 0);
    n_vec++;
    if ({imem_read, imem_addr, instr_vld} !== {1'b1, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL wrap_next_addr got %h want %h", {imem_read, imem_addr, instr_vld}, {1'b1, 32'h0, 1'b1});
    end
    step(0, 0, 0, 1);
    n_vec++;
    if (dut_vec !== exp_vec) begin
      n_err++; $display("FAIL busy_before_reset got %h want %h", dut_vec, exp_vec);
    end
    // Drop reset between clock edges while the read is outstanding.
    #2 rst_n = 0;
    #1;
    n_vec++;
    if ({imem_read, pc_out, instr_out, instr_vld} !== {1'b0, 32'h0, NOP, 1'b0}) begin
      n_err++; $display("FAIL async_reset got %h want %h", {imem_read, pc_out, instr_out, instr_vld},
                        {1'b0, 32'h0, NOP, 1'b0});
    end
    model_reset();
    busy = 0;
    @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL after_reset[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    salt = $urandom;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 2) == 0);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL random[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 0; stall = 0; br = 0; tgt = 0; busy = 0; salt = 0;
    model_reset();
    test_reset();
    test_busywait();
    test_stall_hold();
    test_branch_drain();
    test_branch_in_hold();
    test_wrap_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
